// File: rtl/address_gen_unit.sv
// Registered 65C02 address generator: high/low source select, optional X/Y indexing with a
// one-cycle page-crossing fix-up, post-increment for pointer/vector fetches, and bus-enable gate.
module address_gen_unit #(
  parameter int unsigned           ADDR_W     = 16,
  parameter logic [ADDR_W-9:0]     STACK_PAGE = 'h01,
  parameter logic [ADDR_W-1:0]     RESET_ADDR = 'hFFFC
) (
  input  logic                fclk,
  input  logic                resb,
  input  logic                be,
  input  logic                load,
  input  logic                inc,
  input  logic [2:0]          hmode_select,
  input  logic [2:0]          lmode_select,
  input  logic [1:0]          idx_mode,
  input  logic                page_wrap,
  input  logic [7:0]          y_in,
  input  logic [7:0]          x_in,
  input  logic [7:0]          sp_in,
  input  logic [7:0]          alu_in,
  input  logic [7:0]          pcl_in,
  input  logic [ADDR_W-9:0]   pch_in,
  input  logic [ADDR_W-9:0]   dl_hi,
  input  logic [7:0]          dl_lo,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                addr_oe,
  output logic [7:0]          alu_out,
  output logic [7:0]          pcl_out,
  output logic [ADDR_W-9:0]   pch_out,
  output logic                busy,
  output logic                dummy,
  output logic                page_cross
);

  localparam int unsigned HI_W = ADDR_W - 8;
  localparam logic [HI_W-1:0]   HiOne   = 1;
  localparam logic [ADDR_W-1:0] AddrOne = 1;

  typedef enum logic [0:0] {StIdle, StFixup} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              dummy_q;
  logic              page_cross_q;

  logic [HI_W-1:0]   hi_sel;
  logic [7:0]        lo_sel;
  logic [7:0]        idx_val;
  logic [8:0]        sum;

  // Undefined select codes resolve to zero so the bus never sees X.
  always_comb begin
    hi_sel = '0;
    case (hmode_select)
      3'b010:  hi_sel = STACK_PAGE;
      3'b110:  hi_sel = dl_hi;
      3'b101:  hi_sel = pch_in;
      3'b111:  hi_sel = addr_q[ADDR_W-1:8];
      default: hi_sel = '0;
    endcase
  end

  always_comb begin
    lo_sel = '0;
    case (lmode_select)
      3'b000:  lo_sel = y_in;
      3'b001:  lo_sel = x_in;
      3'b010:  lo_sel = sp_in;
      3'b011:  lo_sel = alu_in;
      3'b101:  lo_sel = pcl_in;
      3'b110:  lo_sel = dl_lo;
      3'b111:  lo_sel = addr_q[7:0];
      default: lo_sel = '0;
    endcase
  end

  always_comb begin
    idx_val = '0;
    case (idx_mode)
      2'b01:   idx_val = x_in;
      2'b10:   idx_val = y_in;
      default: idx_val = '0;
    endcase
  end

  assign sum = {1'b0, lo_sel} + {1'b0, idx_val};

  always_ff @(posedge fclk) begin
    if (!resb) begin
      state_q      <= StIdle;
      addr_q       <= RESET_ADDR;
      dummy_q      <= 1'b0;
      page_cross_q <= 1'b0;
    end else begin
      dummy_q      <= 1'b0;
      page_cross_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load) begin
            addr_q <= {hi_sel, sum[7:0]};
            // Uncorrected address goes out first as a dummy read; high byte fixed next cycle.
            if (sum[8] && !page_wrap) begin
              dummy_q <= 1'b1;
              state_q <= StFixup;
            end
          end else if (inc) begin
            if (page_wrap) addr_q[7:0] <= addr_q[7:0] + 8'd1;
            else           addr_q      <= addr_q + AddrOne;
          end
        end
        StFixup: begin
          addr_q[ADDR_W-1:8] <= addr_q[ADDR_W-1:8] + HiOne;
          page_cross_q       <= 1'b1;
          state_q            <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign addr_out   = addr_q;
  assign addr_oe    = be;
  assign alu_out    = lo_sel;
  assign pcl_out    = lo_sel;
  assign pch_out    = hi_sel;
  assign busy       = (state_q == StFixup);
  assign dummy      = dummy_q;
  assign page_cross = page_cross_q;

endmodule

// File: tb/tb_address_gen_unit.sv
// Directed bench for address_gen_unit: load paths, indexing, page-cross fix-up, increments,
// reset behaviour and undefined select codes.
module tb_address_gen_unit;

  logic        fclk = 1'b0;
  logic        resb, be, load, inc, page_wrap;
  logic [2:0]  hmode_select, lmode_select;
  logic [1:0]  idx_mode;
  logic [7:0]  y_in, x_in, sp_in, alu_in, pcl_in, pch_in, dl_hi, dl_lo;
  logic [15:0] addr_out;
  logic        addr_oe, busy, dummy, page_cross;
  logic [7:0]  alu_out, pcl_out, pch_out;

  int checks = 0;
  int errors = 0;

  address_gen_unit dut (
    .fclk(fclk), .resb(resb), .be(be), .load(load), .inc(inc),
    .hmode_select(hmode_select), .lmode_select(lmode_select), .idx_mode(idx_mode),
    .page_wrap(page_wrap), .y_in(y_in), .x_in(x_in), .sp_in(sp_in), .alu_in(alu_in),
    .pcl_in(pcl_in), .pch_in(pch_in), .dl_hi(dl_hi), .dl_lo(dl_lo),
    .addr_out(addr_out), .addr_oe(addr_oe), .alu_out(alu_out), .pcl_out(pcl_out),
    .pch_out(pch_out), .busy(busy), .dummy(dummy), .page_cross(page_cross)
  );

  always #5 fclk = ~fclk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; inc = 0; idx_mode = 2'b00; page_wrap = 0;
    hmode_select = 3'b111; lmode_select = 3'b111;
  endtask

  task automatic test_reset();
    resb = 0; be = 1; load = 1; inc = 1;
    hmode_select = 3'b101; lmode_select = 3'b101; pch_in = 8'h12; pcl_in = 8'h34;
    step();
    checks++; if (addr_out !== 16'hFFFC) begin errors++;
      $display("FAIL reset_addr: got %h exp %h", addr_out, 16'hFFFC); end
    checks++; if ({busy, dummy, page_cross} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b exp 000", {busy, dummy, page_cross}); end
    resb = 1; idle_inputs();
  endtask

  task automatic test_load_pc();
    hmode_select = 3'b101; lmode_select = 3'b101; pch_in = 8'h12; pcl_in = 8'h34; load = 1;
    #1;
    checks++; if ({pch_out, pcl_out, alu_out} !== 24'h123434) begin errors++;
      $display("FAIL sel_outs: got %h exp 123434", {pch_out, pcl_out, alu_out}); end
    step(); idle_inputs();
    checks++; if (addr_out !== 16'h1234 || dummy !== 1'b0) begin errors++;
      $display("FAIL load_pc: got %h/%b exp 1234/0", addr_out, dummy); end
  endtask

  task automatic load_abs_x_cross();
    hmode_select = 3'b110; lmode_select = 3'b110; dl_hi = 8'h20; dl_lo = 8'hF0;
    x_in = 8'h20; idx_mode = 2'b01; page_wrap = 0; load = 1;
    step(); idle_inputs();
  endtask

  task automatic test_abs_x_cross();
    load_abs_x_cross();
    checks++; if ({addr_out, dummy, busy, page_cross} !== {16'h2010, 3'b110}) begin errors++;
      $display("FAIL absx_dummy: got %h %b%b%b exp 2010 110", addr_out, dummy, busy, page_cross); end
    step();
    checks++; if ({addr_out, dummy, busy, page_cross} !== {16'h2110, 3'b001}) begin errors++;
      $display("FAIL absx_fix: got %h %b%b%b exp 2110 001", addr_out, dummy, busy, page_cross); end
    step();
    checks++; if ({addr_out, page_cross, busy} !== {16'h2110, 2'b00}) begin errors++;
      $display("FAIL absx_after: got %h %b%b exp 2110 00", addr_out, page_cross, busy); end
  endtask

  task automatic test_zp_wrap();
    hmode_select = 3'b000; lmode_select = 3'b110; dl_lo = 8'hF0; x_in = 8'h20;
    idx_mode = 2'b01; page_wrap = 1; load = 1;
    step(); idle_inputs();
    checks++; if ({addr_out, dummy, busy} !== {16'h0010, 2'b00}) begin errors++;
      $display("FAIL zpx_wrap: got %h %b%b exp 0010 00", addr_out, dummy, busy); end
    step();
    checks++; if ({addr_out, page_cross} !== {16'h0010, 1'b0}) begin errors++;
      $display("FAIL zpx_nofix: got %h %b exp 0010 0", addr_out, page_cross); end
  endtask

  task automatic test_inc();
    hmode_select = 3'b110; lmode_select = 3'b110; dl_hi = 8'hFF; dl_lo = 8'hFF; load = 1;
    step(); idle_inputs();
    inc = 1; step(); inc = 0;
    checks++; if (addr_out !== 16'h0000) begin errors++;
      $display("FAIL inc_full_wrap: got %h exp 0000", addr_out); end
    hmode_select = 3'b000; lmode_select = 3'b110; dl_lo = 8'hFF; load = 1;
    step(); idle_inputs();
    inc = 1; page_wrap = 1; step(); inc = 0; page_wrap = 0;
    checks++; if (addr_out !== 16'h0000) begin errors++;
      $display("FAIL inc_page_wrap: got %h exp 0000", addr_out); end
    hmode_select = 3'b000; lmode_select = 3'b110; dl_lo = 8'hFF; load = 1;
    step(); idle_inputs();
    inc = 1; step(); inc = 0;
    checks++; if (addr_out !== 16'h0100) begin errors++;
      $display("FAIL inc_carry: got %h exp 0100", addr_out); end
    hmode_select = 3'b101; lmode_select = 3'b101; pch_in = 8'h12; pcl_in = 8'h34;
    load = 1; inc = 1; step(); idle_inputs();
    checks++; if (addr_out !== 16'h1234) begin errors++;
      $display("FAIL load_beats_inc: got %h exp 1234", addr_out); end
  endtask

  task automatic test_fixup_ignore();
    load_abs_x_cross();
    hmode_select = 3'b101; lmode_select = 3'b101; pch_in = 8'h55; pcl_in = 8'h66;
    load = 1; inc = 1;
    step(); idle_inputs();
    checks++; if ({addr_out, page_cross} !== {16'h2110, 1'b1}) begin errors++;
      $display("FAIL fixup_ignore: got %h %b exp 2110 1", addr_out, page_cross); end
    step();
    checks++; if (addr_out !== 16'h2110) begin errors++;
      $display("FAIL fixup_noqueue: got %h exp 2110", addr_out); end
  endtask

  task automatic test_reset_fixup();
    load_abs_x_cross();
    resb = 0; step(); resb = 1;
    checks++; if ({addr_out, busy, dummy, page_cross} !== {16'hFFFC, 3'b000}) begin errors++;
      $display("FAIL reset_fixup: got %h %b%b%b exp FFFC 000", addr_out, busy, dummy, page_cross); end
    step();
    checks++; if ({addr_out, page_cross} !== {16'hFFFC, 1'b0}) begin errors++;
      $display("FAIL reset_fixup_after: got %h %b exp FFFC 0", addr_out, page_cross); end
  endtask

  task automatic test_selects();
    hmode_select = 3'b110; dl_hi = 8'hAB; lmode_select = 3'b100; load = 1;
    step(); idle_inputs();
    checks++; if (addr_out !== 16'hAB00) begin errors++;
      $display("FAIL undef_lmode: got %h exp AB00", addr_out); end
    hmode_select = 3'b001; lmode_select = 3'b101; pcl_in = 8'h34; load = 1;
    step(); idle_inputs();
    checks++; if (addr_out !== 16'h0034) begin errors++;
      $display("FAIL undef_hmode: got %h exp 0034", addr_out); end
    hmode_select = 3'b010; lmode_select = 3'b010; sp_in = 8'hFD; load = 1;
    step(); idle_inputs();
    checks++; if (addr_out !== 16'h01FD) begin errors++;
      $display("FAIL stack: got %h exp 01FD", addr_out); end
    hmode_select = 3'b010; lmode_select = 3'b001; x_in = 8'h10; y_in = 8'h05;
    idx_mode = 2'b10; load = 1;
    step(); idle_inputs();
    checks++; if (addr_out !== 16'h0115) begin errors++;
      $display("FAIL x_plus_y: got %h exp 0115", addr_out); end
    load = 1; step(); idle_inputs();
    checks++; if (addr_out !== 16'h0115) begin errors++;
      $display("FAIL hold: got %h exp 0115", addr_out); end
    hmode_select = 3'b000; lmode_select = 3'b011; alu_in = 8'h40; x_in = 8'h10;
    idx_mode = 2'b11; load = 1;
    step(); idle_inputs();
    checks++; if (addr_out !== 16'h0040) begin errors++;
      $display("FAIL idx_reserved: got %h exp 0040", addr_out); end
  endtask

  task automatic test_bus_enable();
    be = 0; #1;
    checks++; if (addr_oe !== 1'b0) begin errors++;
      $display("FAIL oe_low: got %b exp 0", addr_oe); end
    hmode_select = 3'b101; lmode_select = 3'b101; pch_in = 8'h9A; pcl_in = 8'hBC; load = 1;
    step(); idle_inputs();
    checks++; if (addr_out !== 16'h9ABC) begin errors++;
      $display("FAIL be_off_update: got %h exp 9ABC", addr_out); end
    be = 1; #1;
    checks++; if (addr_oe !== 1'b1) begin errors++;
      $display("FAIL oe_high: got %b exp 1", addr_oe); end
  endtask

  initial begin
    resb = 0; be = 1; idle_inputs();
    y_in = 0; x_in = 0; sp_in = 0; alu_in = 0; pcl_in = 0; pch_in = 0; dl_hi = 0; dl_lo = 0;
    #2;
    test_reset();
    test_load_pc();
    test_abs_x_cross();
    test_zp_wrap();
    test_inc();
    test_fixup_ignore();
    test_reset_fixup();
    test_selects();
    test_bus_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
